// File: rtl/poly_mem_reader_if.sv
// rtl/poly_mem_reader_if.sv - control, memory read port and output stream bundle for poly_mem_reader
`timescale 1ns/1ps
interface poly_mem_reader_if #(
  parameter int RAM_WIDTH     = 13,
  parameter int RAM_ADDR_BITS = 11
);
  // Transfer control
  logic                     start;
  logic [RAM_ADDR_BITS-1:0] base_addr;
  logic [RAM_ADDR_BITS-1:0] len;
  logic                     abort;
  logic                     busy;
  logic                     done;
  // Distributed-RAM asynchronous read port
  logic [RAM_ADDR_BITS-1:0] read_address;
  logic [RAM_WIDTH-1:0]     read_data;
  // Output stream
  logic [RAM_WIDTH-1:0]     out_data;
  logic                     out_valid;
  logic                     out_ready;
  logic                     out_last;

  // Reader side
  modport master (
    input  start, base_addr, len, abort, read_data, out_ready,
    output busy, done, read_address, out_data, out_valid, out_last
  );

  // Controller, memory and consumer side
  modport slave (
    output start, base_addr, len, abort, read_data, out_ready,
    input  busy, done, read_address, out_data, out_valid, out_last
  );
endinterface

// File: rtl/poly_mem_reader.sv
// rtl/poly_mem_reader.sv - streams a coefficient block out of distributed RAM with backpressure
`timescale 1ns/1ps
module poly_mem_reader #(
  parameter int RAM_WIDTH     = 13,
  parameter int RAM_ADDR_BITS = 11
) (
  input  logic              clk,
  input  logic              rst,
  poly_mem_reader_if.master bus
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, FIN} state_t;

  state_t                   state;
  state_t                   state_next;
  logic                     take_start;
  logic                     load;
  logic                     clear_out;
  logic [RAM_ADDR_BITS-1:0] read_address;
  logic [RAM_ADDR_BITS-1:0] remaining;
  logic [RAM_WIDTH-1:0]     out_data;
  logic                     out_valid;
  logic                     out_last;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and datapath strobes; abort outranks both a load and the final beat
  always_comb begin
    state_next = state;
    take_start = 1'b0;
    load       = 1'b0;
    clear_out  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (bus.len != '0) begin
            take_start = 1'b1;
            state_next = READ;
          end else begin
            state_next = FIN;
          end
        end
      end
      READ: begin
        if (bus.abort) begin
          clear_out  = 1'b1;
          state_next = IDLE;
        end else if (!out_valid || bus.out_ready) begin
          load = 1'b1;
          if (remaining == RAM_ADDR_BITS'(1)) begin
            state_next = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (bus.abort) begin
          clear_out  = 1'b1;
          state_next = IDLE;
        end else if (bus.out_ready) begin
          clear_out  = 1'b1;
          state_next = FIN;
        end
      end
      FIN: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Address/count bookkeeping and the registered output word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      read_address <= '0;
      remaining    <= '0;
      out_data     <= '0;
      out_valid    <= 1'b0;
      out_last     <= 1'b0;
    end else begin
      if (take_start) begin
        read_address <= bus.base_addr;
        remaining    <= bus.len;
      end
      if (load) begin
        out_data     <= bus.read_data;
        out_valid    <= 1'b1;
        out_last     <= (remaining == RAM_ADDR_BITS'(1));
        read_address <= read_address + RAM_ADDR_BITS'(1);
        remaining    <= remaining - RAM_ADDR_BITS'(1);
      end
      if (clear_out) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

  assign bus.read_address = read_address;
  assign bus.out_data     = out_data;
  assign bus.out_valid    = out_valid;
  assign bus.out_last     = out_last;
  assign bus.busy         = (state != IDLE);
  assign bus.done         = (state == FIN);

endmodule

// File: tb/tb_poly_mem_reader.sv
// tb/tb_poly_mem_reader.sv - scoreboard bench for poly_mem_reader
`timescale 1ns/1ps
module tb_poly_mem_reader;
  localparam int W = 13;
  localparam int A = 11;

  logic clk = 1'b0;
  logic rst = 1'b1;

  poly_mem_reader_if #(.RAM_WIDTH(W), .RAM_ADDR_BITS(A)) bus ();

  poly_mem_reader #(.RAM_WIDTH(W), .RAM_ADDR_BITS(A)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  logic [W-1:0] key = '0;
  logic [W:0]   exp_q[$];
  logic [W:0]   mon_e;

  int cyc             = 0;
  int beat_count      = 0;
  int done_count      = 0;
  int busy_cycles     = 0;
  int valid_rises     = 0;
  int last_beat_cyc   = -1;
  int done_cyc        = -1;
  int first_valid_cyc = -1;
  int start_cyc       = 0;

  logic         prev_valid = 1'b0;
  logic         prev_ready = 1'b0;
  logic         prev_abort = 1'b0;
  logic [W-1:0] prev_data  = '0;

  // Memory contents: word at address a is a XOR key
  function automatic logic [W-1:0] mem_word(input logic [A-1:0] a, input logic [W-1:0] k);
    return {{(W-A){1'b0}}, a} ^ k;
  endfunction

  assign bus.read_data = mem_word(bus.read_address, key);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: scoreboard pops, stall stability and event bookkeeping
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
      prev_ready = 1'b0;
      prev_abort = 1'b0;
    end else begin
      if (bus.out_valid && !prev_valid) begin
        valid_rises++;
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
      end
      if (prev_valid && !prev_ready && !prev_abort) begin
        check_eq("stall_valid", bus.out_valid, 1);
        check_eq("stall_data", bus.out_data, prev_data);
      end
      if (bus.busy) busy_cycles++;
      if (bus.done) begin
        done_count++;
        done_cyc = cyc;
      end
      if (bus.out_valid && bus.out_ready && !bus.abort) begin
        beat_count++;
        check_eq("beat_expected", (exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check_eq("data", bus.out_data, mon_e[W-1:0]);
          check_eq("last", bus.out_last, mon_e[W]);
        end
        if (bus.out_last) last_beat_cyc = cyc;
      end
      prev_valid = bus.out_valid;
      prev_ready = bus.out_ready;
      prev_abort = bus.abort;
      prev_data  = bus.out_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_xfer(input logic [A-1:0] base, input int n, input logic [W-1:0] k);
    logic [A-1:0] a;
    key = k;
    for (int i = 0; i < n; i++) begin
      a = A'(int'(base) + i);
      exp_q.push_back({(i == n - 1), mem_word(a, k)});
    end
    bus.base_addr   = base;
    bus.len         = A'(n);
    bus.start       = 1'b1;
    start_cyc       = cyc;
    first_valid_cyc = -1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max_cycles, input bit bp);
    int dc0;
    int n;
    dc0 = done_count;
    n = 0;
    while (n < max_cycles && done_count == dc0) begin
      tick();
      if (bp) bus.out_ready = ((n % 4) == 2) || ((n % 4) == 3) ? ((n % 4) == 2 ? 1'b1 : 1'b0) : ((n % 4) == 0 ? 1'b0 : 1'b1);
      n++;
    end
    bus.out_ready = 1'b1;
    check_eq({tag, "_done"}, done_count - dc0, 1);
  endtask

  initial begin
    int b0;
    int dc0;
    int bc0;
    int vr0;
    int n;
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.base_addr = '0;
    bus.len       = '0;
    bus.out_ready = 1'b1;

    // Reset state
    tick();
    tick();
    check_eq("rst_addr", bus.read_address, 0);
    check_eq("rst_valid", bus.out_valid, 0);
    check_eq("rst_last", bus.out_last, 0);
    check_eq("rst_data", bus.out_data, 0);
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_done", bus.done, 0);

    // Full stream, started in the first cycle after reset release
    rst = 1'b0;
    b0 = beat_count;
    start_xfer(11'd0, 761, '0);
    wait_done("full", 2000, 1'b0);
    check_eq("full_first_valid", first_valid_cyc - start_cyc, 2);
    check_eq("full_done_after_last", done_cyc - last_beat_cyc, 1);
    check_eq("full_done_cyc", done_cyc - start_cyc, 763);
    check_eq("full_beats", beat_count - b0, 761);
    check_eq("full_q_empty", exp_q.size(), 0);

    // Backpressure
    b0 = beat_count;
    start_xfer(11'd0, 4, '0);
    wait_done("bp", 100, 1'b1);
    check_eq("bp_beats", beat_count - b0, 4);
    check_eq("bp_q_empty", exp_q.size(), 0);

    // Address wrap
    start_xfer(11'd2046, 4, '0);
    wait_done("wrap", 100, 1'b0);
    check_eq("wrap_done_cyc", done_cyc - start_cyc, 6);
    check_eq("wrap_addr_after", bus.read_address, 2);
    check_eq("wrap_q_empty", exp_q.size(), 0);

    // Zero-length request
    bc0 = busy_cycles;
    vr0 = valid_rises;
    dc0 = done_count;
    start_xfer(11'd5, 0, '0);
    wait_done("len0", 20, 1'b0);
    check_eq("len0_done_cyc", done_cyc - start_cyc, 1);
    check_eq("len0_busy", busy_cycles - bc0, 1);
    tick(); tick(); tick();
    check_eq("len0_valid_rises", valid_rises - vr0, 0);
    check_eq("len0_single_done", done_count - dc0, 1);

    // Abort on the third beat
    b0 = beat_count;
    start_xfer(11'd100, 10, 13'h5);
    n = 0;
    while (n < 50 && (beat_count - b0) < 2) begin
      tick();
      n++;
    end
    check_eq("abort_reach_beat3", beat_count - b0, 2);
    check_eq("abort_beat3_valid", bus.out_valid, 1);
    dc0 = done_count;
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check_eq("abort_valid", bus.out_valid, 0);
    check_eq("abort_last", bus.out_last, 0);
    check_eq("abort_idle", bus.busy, 0);
    for (int i = 0; i < 5; i++) tick();
    check_eq("abort_no_done", done_count - dc0, 0);
    check_eq("abort_beats", beat_count - b0, 2);
    exp_q.delete();
    start_xfer(11'd300, 6, 13'h3);
    wait_done("after_abort", 100, 1'b0);
    check_eq("after_abort_q_empty", exp_q.size(), 0);

    // Start while busy is ignored, then reset mid-transfer
    start_xfer(11'd0, 50, '0);
    for (int i = 0; i < 5; i++) tick();
    bus.base_addr = 11'd500;
    bus.len       = 11'd3;
    bus.start     = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check_eq("busy_mid", bus.busy, 1);
    rst = 1'b1;
    #1;
    check_eq("mrst_addr", bus.read_address, 0);
    check_eq("mrst_valid", bus.out_valid, 0);
    check_eq("mrst_last", bus.out_last, 0);
    check_eq("mrst_data", bus.out_data, 0);
    check_eq("mrst_busy", bus.busy, 0);
    check_eq("mrst_done", bus.done, 0);
    exp_q.delete();
    dc0 = done_count;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check_eq("mrst_no_done", done_count - dc0, 0);
    check_eq("mrst_idle", bus.busy, 0);
    start_xfer(11'd7, 3, '0);
    wait_done("final", 100, 1'b0);
    check_eq("final_q_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/poly_mem_reader.md
POLY_MEM_READER -- requirements
Module: poly_mem_reader

Interface
REQ-001 The block SHALL have parameter RAM_WIDTH, default 13, giving the coefficient word width.
REQ-002 The block SHALL have parameter RAM_ADDR_BITS, default 11, giving the memory address width.
REQ-003 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1: asynchronous, active-high reset.
REQ-005 Port start, input, 1: a one-cycle pulse that requests a transfer; it SHALL be sampled only in IDLE.
REQ-006 Port base_addr, input, RAM_ADDR_BITS: first address to read; sampled with start.
REQ-007 Port len, input, RAM_ADDR_BITS: number of words to read (0 to 2047); sampled with start.
REQ-008 Port abort, input, 1: synchronous cancel of the current transfer.
REQ-009 Port read_address, output, RAM_ADDR_BITS: address driven to the distributed-RAM asynchronous read port.
REQ-010 Port read_data, input, RAM_WIDTH: combinational memory output for read_address in the same cycle.
REQ-011 Port out_data, output, RAM_WIDTH: registered stream data.
REQ-012 Port out_valid, output, 1: out_data holds a valid word.
REQ-013 Port out_ready, input, 1: the consumer accepts a word; a beat SHALL complete on out_valid && out_ready.
REQ-014 Port out_last, output, 1: asserted with out_valid on the final word of the transfer.
REQ-015 Port busy, output, 1: high in every state except IDLE.
REQ-016 Port done, output, 1: a one-cycle pulse when a transfer completes.

Function
REQ-017 The state machine SHALL have the states IDLE, READ, DRAIN and FIN.
REQ-018 In IDLE with start=1 and len!=0: read_address<=base_addr, remaining<=len, next state READ.
REQ-019 In IDLE with start=1 and len=0: next state FIN; no beat SHALL be produced.
REQ-020 In READ, a load SHALL occur when !out_valid || out_ready.
- Load effects: out_data<=read_data, out_valid<=1, read_address<=read_address+1, remaining<=remaining-1.
REQ-021 out_last SHALL be set on the load where remaining==1; that load SHALL move the state to DRAIN.
REQ-022 In READ, when no load occurs, out_data, out_valid, out_last, read_address and remaining SHALL hold.
REQ-023 Throughput SHALL be one word per cycle under continuous out_ready=1.
REQ-024 Latency SHALL be as follows:
- The first out_valid appears in the cycle after start is sampled.
- No bubbles occur between beats while out_ready=1.
REQ-025 read_address SHALL increment modulo 2**RAM_ADDR_BITS (2047+1 -> 0).
REQ-026 In DRAIN, on the beat with out_last=1:
- out_valid<=0 and out_last<=0.
- Next state FIN.
REQ-027 FIN SHALL last one cycle with done=1, then go to IDLE.
REQ-028 out_data SHALL remain stable while out_valid && !out_ready.
REQ-029 start asserted in READ, DRAIN or FIN SHALL be ignored.
REQ-030 abort=1 in READ or DRAIN SHALL act next edge:
- out_valid<=0, out_last<=0, next state IDLE.
- No done pulse.
- abort has priority over a load or beat in the same cycle.
REQ-031 abort in IDLE or FIN SHALL have no effect.
REQ-032 The block SHALL never write memory; it is the read-side companion of the write-only loader.

Reset
REQ-033 On rst=1, asynchronously and regardless of state:
- State=IDLE.
- read_address=0, out_data=0, remaining=0.
- out_valid=0, out_last=0, busy=0, done=0.
REQ-034 Reset during a transfer SHALL discard the transfer; no done SHALL follow its release.
REQ-035 The first start SHALL be honoured in the first cycle after rst deasserts.

Verification
REQ-036 Full stream: base=0, len=761, out_ready=1, memory word at address k is k.
- Expected: 761 consecutive beats with data 0..760.
- out_last only on 760; done exactly one cycle after the last beat.
REQ-037 Backpressure: len=4, out_ready toggling 1,0,0,1,...
- Expected: data stable while stalled, no word lost or duplicated, order 0..3.
REQ-038 Wrap: base=2046, len=4.
- Expected: read addresses 2046, 2047, 0, 1; out_last on the word from address 1.
REQ-039 len=0 start.
- Expected: out_valid never rises; done pulses one cycle later.
- busy is high for exactly one cycle.
REQ-040 abort on the 3rd beat of len=10.
- Expected: out_valid low next cycle, state IDLE, no done.
- A new start then streams correctly.
REQ-041 rst pulse mid-transfer, plus start while busy.
- Expected: all outputs zero immediately on reset.
- The start issued while busy is ignored.
